// File: rtl/elu_lookup_ctrl.sv
// ELU table ROM sequencer: clamps signed samples to a ROM address, captures rom_q into a
// 3-entry FIFO and streams results with per-frame last flags. Optional: ELU_SAT_CNT_EN.
module elu_lookup_ctrl #(
  parameter int IWIDTH = 16,
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 11,
  parameter int WORDS  = 1597,
  parameter int OFFSET = 798,
  parameter int NUM    = 1024,
  parameter int CWIDTH = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IWIDTH-1:0] in_data,
  output logic [AWIDTH-1:0] rom_addr,
  input  logic [DWIDTH-1:0] rom_q,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_last,
  output logic              busy
`ifdef ELU_SAT_CNT_EN
  ,
  output logic [15:0]       sat_count
`endif
);

  localparam int SW = IWIDTH + 2;
  localparam logic signed [SW-1:0] OFF_S  = SW'(OFFSET);
  localparam logic signed [SW-1:0] MAX_S  = SW'(WORDS - 1);
  localparam logic [AWIDTH-1:0]    MAX_A  = AWIDTH'(WORDS - 1);
  localparam logic [CWIDTH-1:0]    LAST_C = CWIDTH'(NUM - 1);

  logic signed [SW-1:0] sum;
  logic                 clamp_lo;
  logic                 clamp_hi;

  logic [DWIDTH-1:0]    mem [3];
  logic [1:0]           wr_ptr;
  logic [1:0]           rd_ptr;
  logic [1:0]           count;
  logic                 pending;
  logic [CWIDTH-1:0]    frame;
  logic                 accept;
  logic                 pop;

  // Two guard bits keep the offset sum exact for any input.
  assign sum      = {{2{in_data[IWIDTH-1]}}, in_data} + OFF_S;
  assign clamp_lo = sum[SW-1];
  assign clamp_hi = !sum[SW-1] && (sum > MAX_S);
  assign rom_addr = clamp_lo ? '0 : (clamp_hi ? MAX_A : sum[AWIDTH-1:0]);

  // Counting the pending read reserves a FIFO slot for it before it lands.
  assign in_ready  = !rst && (({1'b0, count} + {2'b00, pending}) <= 3'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign out_last  = out_valid && (frame == LAST_C);
  assign busy      = pending || out_valid;

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      pending <= 1'b0;
      frame   <= '0;
    end else begin
      pending <= accept;
      if (pending) begin
        mem[wr_ptr] <= rom_q;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
        frame  <= (frame == LAST_C) ? '0 : frame + CWIDTH'(1);
      end
      case ({pending, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef ELU_SAT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_count <= '0;
    end else if (accept && (clamp_lo || clamp_hi) && (sat_count != 16'hFFFF)) begin
      sat_count <= sat_count + 16'd1;
    end
  end
`endif

endmodule
